// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for a single-port DataMemory.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie (port 1 can starve).
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rbar_w,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // One extra bit keeps the compare unsigned over the full address width.
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic              busy_r;
    logic              grant_r;
    logic              we_r;
    logic              ack0_r;
    logic              ack1_r;
    logic              err0_r;
    logic              err1_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_rbar_w_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic              any_req_s;
    logic              tie_grant_s;
    logic              grant_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              oor_s;

    assign any_req_s = req0 | req1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 takes every tie, so no fairness history is kept.
    always_comb begin
        tie_grant_s = 1'b0;
    end
`else
    logic last_grant_r;

    // Round-robin history: the port served last loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            last_grant_r <= grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Tie winner is the port that did not win last time.
    always_comb begin
        tie_grant_s = ~last_grant_r;
    end
`endif

    // Select the winning requester and range-check its address.
    always_comb begin
        grant_s = 1'b0;
        if (req0 && req1) begin
            grant_s = tie_grant_s;
        end else if (req0) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
        sel_we_s    = grant_s ? we1    : we0;
        sel_addr_s  = grant_s ? addr1  : addr0;
        sel_wdata_s = grant_s ? wdata1 : wdata0;
        oor_s       = ({1'b0, sel_addr_s} >= DEPTH_LIMIT);
    end

    // Next-state decode; out-of-range requests skip straight to DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = oor_s ? ST_DONE : ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP:  next_state_s = ST_ACCESS;
            ST_ACCESS: next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Sequencer registers: every output is driven from a flop so rbar_w never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            grant_r      <= 1'b0;
            we_r         <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
            mem_addr_r   <= '0;
            mem_rbar_w_r <= 1'b0;
            mem_wdata_r  <= '0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    mem_rbar_w_r <= 1'b0;
                    if (any_req_s) begin
                        grant_r <= grant_s;
                        we_r    <= sel_we_s;
                        if (oor_s) begin
                            ack0_r <= ~grant_s;
                            err0_r <= ~grant_s;
                            ack1_r <= grant_s;
                            err1_r <= grant_s;
                        end else begin
                            mem_addr_r  <= sel_addr_s;
                            mem_wdata_r <= sel_wdata_s;
                        end
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                ST_SETUP: begin
                    mem_rbar_w_r <= we_r;
                end
                ST_ACCESS: begin
                    mem_rbar_w_r <= 1'b0;
                    ack0_r       <= ~grant_r;
                    ack1_r       <= grant_r;
                    if (!we_r) begin
                        if (grant_r) begin
                            rdata1_r <= mem_rdata;
                        end else begin
                            rdata0_r <= mem_rdata;
                        end
                    end else begin
                        rdata0_r <= rdata0_r;
                    end
                end
                ST_DONE: begin
                    mem_rbar_w_r <= 1'b0;
                end
                default: begin
                    mem_rbar_w_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack0       = ack0_r;
    assign ack1       = ack1_r;
    assign err0       = err0_r;
    assign err1       = err1_r;
    assign rdata0     = rdata0_r;
    assign rdata1     = rdata1_r;
    assign mem_addr   = mem_addr_r;
    assign mem_rbar_w = mem_rbar_w_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;

endmodule
